// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite register bridge: response codes,
// write/read FSM state encodings and the register address decode helper.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE   = 3'd0,
        W_GOT_AW = 3'd1,
        W_GOT_W  = 3'd2,
        W_EXEC   = 3'd3,
        W_RESP   = 3'd4
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_EXEC = 2'd1,
        R_WAIT = 2'd2,
        R_RESP = 2'd3
    } r_state_e;

    // An address hits the register window when it lies below the byte limit
    // (number of registers times four); the low two byte-lane bits never
    // affect which register is selected.
    function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] limit);
        return (addr < limit);
    endfunction

endpackage

// File: rtl/axi4_lite_reg_bridge.sv
// AXI4-Lite slave that turns write/read transactions into single-cycle
// native register strobes. Write and read channels run independently except
// that a native write always takes precedence over a native read strobe.
module axi4_lite_reg_bridge
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic                        s_AWVALID,
    output logic                        s_AWREADY,
    input  logic [ADDR_WIDTH-1:0]       s_AWADDR,
    input  logic [2:0]                  s_AWPROT,
    input  logic                        s_WVALID,
    output logic                        s_WREADY,
    input  logic [DATA_WIDTH-1:0]       s_WDATA,
    input  logic [DATA_WIDTH/8-1:0]     s_WSTRB,
    output logic                        s_BVALID,
    input  logic                        s_BREADY,
    output logic [1:0]                  s_BRESP,
    input  logic                        s_ARVALID,
    output logic                        s_ARREADY,
    input  logic [ADDR_WIDTH-1:0]       s_ARADDR,
    input  logic [2:0]                  s_ARPROT,
    output logic                        s_RVALID,
    input  logic                        s_RREADY,
    output logic [DATA_WIDTH-1:0]       s_RDATA,
    output logic [1:0]                  s_RRESP,
    output logic                        oREG_WE,
    output logic                        oREG_RE,
    output logic [$clog2(NUM_REGS)-1:0] oREG_IDX,
    output logic [DATA_WIDTH-1:0]       oREG_WDATA,
    output logic [DATA_WIDTH/8-1:0]     oREG_WSTRB,
    input  logic [DATA_WIDTH-1:0]       iREG_RDATA
);

    localparam int          IDX_W     = $clog2(NUM_REGS);
    localparam int          STRB_W    = DATA_WIDTH / 8;
    localparam logic [63:0] REG_LIMIT = 64'(NUM_REGS) * 64'd4;

    // Write channel state and latches
    w_state_e               r_wstate;
    logic                   r_awready;
    logic                   r_wready;
    logic                   r_bvalid;
    logic [1:0]             r_bresp;
    logic                   r_reg_we;
    logic [IDX_W-1:0]       r_widx;
    logic                   r_w_inrange;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [STRB_W-1:0]      r_wstrb;

    // Read channel state and latches
    r_state_e               r_rstate;
    logic                   r_arready;
    logic                   r_rvalid;
    logic [1:0]             r_rresp;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_reg_re;
    logic [IDX_W-1:0]       r_ridx;
    logic                   r_r_inrange;

    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_ar_hs;
    logic                   w_aw_inrange;
    logic                   w_ar_inrange;
    logic [IDX_W-1:0]       w_aw_idx;
    logic [IDX_W-1:0]       w_ar_idx;
    logic                   w_w_exec_nxt;
    logic                   w_unused_prot;

    assign w_aw_hs      = s_AWVALID & r_awready;
    assign w_w_hs       = s_WVALID & r_wready;
    assign w_ar_hs      = s_ARVALID & r_arready;
    assign w_aw_inrange = addr_in_range(64'(s_AWADDR), REG_LIMIT);
    assign w_ar_inrange = addr_in_range(64'(s_ARADDR), REG_LIMIT);
    assign w_aw_idx     = s_AWADDR[2 +: IDX_W];
    assign w_ar_idx     = s_ARADDR[2 +: IDX_W];
    assign w_unused_prot = ^{s_AWPROT, s_ARPROT};

    // The write FSM enters W_EXEC on the coming edge; the read side uses this
    // to hold back its native strobe so the two never overlap.
    assign w_w_exec_nxt = ((r_wstate == W_IDLE)   && w_aw_hs && w_w_hs) ||
                          ((r_wstate == W_GOT_AW) && w_w_hs) ||
                          ((r_wstate == W_GOT_W)  && w_aw_hs);

    // Write FSM: collect AW and W in any order, strobe the register once, respond.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_wstate    <= W_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_reg_we    <= 1'b0;
            r_widx      <= {IDX_W{1'b0}};
            r_w_inrange <= 1'b0;
            r_wdata     <= {DATA_WIDTH{1'b0}};
            r_wstrb     <= {STRB_W{1'b0}};
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs && w_w_hs) begin
                        r_widx      <= w_aw_idx;
                        r_w_inrange <= w_aw_inrange;
                        r_wdata     <= s_WDATA;
                        r_wstrb     <= s_WSTRB;
                        r_awready   <= 1'b0;
                        r_wready    <= 1'b0;
                        r_reg_we    <= w_aw_inrange;
                        r_wstate    <= W_EXEC;
                    end else if (w_aw_hs) begin
                        r_widx      <= w_aw_idx;
                        r_w_inrange <= w_aw_inrange;
                        r_awready   <= 1'b0;
                        r_wready    <= 1'b1;
                        r_wstate    <= W_GOT_AW;
                    end else if (w_w_hs) begin
                        r_wdata     <= s_WDATA;
                        r_wstrb     <= s_WSTRB;
                        r_awready   <= 1'b1;
                        r_wready    <= 1'b0;
                        r_wstate    <= W_GOT_W;
                    end else begin
                        // Readies come up here on the first cycle after reset.
                        r_awready   <= 1'b1;
                        r_wready    <= 1'b1;
                    end
                end
                W_GOT_AW: begin
                    if (w_w_hs) begin
                        r_wdata  <= s_WDATA;
                        r_wstrb  <= s_WSTRB;
                        r_wready <= 1'b0;
                        r_reg_we <= r_w_inrange;
                        r_wstate <= W_EXEC;
                    end
                end
                W_GOT_W: begin
                    if (w_aw_hs) begin
                        r_widx      <= w_aw_idx;
                        r_w_inrange <= w_aw_inrange;
                        r_awready   <= 1'b0;
                        r_reg_we    <= w_aw_inrange;
                        r_wstate    <= W_EXEC;
                    end
                end
                W_EXEC: begin
                    r_reg_we <= 1'b0;
                    r_bvalid <= 1'b1;
                    r_bresp  <= r_w_inrange ? RESP_OKAY : RESP_SLVERR;
                    r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (s_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                    r_reg_we  <= 1'b0;
                    r_wstate  <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: accept AR, strobe the register (yielding to a native write),
    // capture the returned data one cycle later, then hold RVALID.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_rstate    <= R_IDLE;
            r_arready   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rresp     <= RESP_OKAY;
            r_rdata     <= {DATA_WIDTH{1'b0}};
            r_reg_re    <= 1'b0;
            r_ridx      <= {IDX_W{1'b0}};
            r_r_inrange <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_ridx      <= w_ar_idx;
                        r_r_inrange <= w_ar_inrange;
                        r_arready   <= 1'b0;
                        r_reg_re    <= w_ar_inrange & ~w_w_exec_nxt;
                        r_rstate    <= R_EXEC;
                    end else begin
                        r_arready   <= 1'b1;
                    end
                end
                R_EXEC: begin
                    if (r_wstate == W_EXEC) begin
                        // Write owns this cycle; W_EXEC lasts one cycle, so strobe next.
                        r_reg_re <= r_r_inrange;
                    end else begin
                        r_reg_re <= 1'b0;
                        r_rstate <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    r_rdata  <= r_r_inrange ? iREG_RDATA : {DATA_WIDTH{1'b0}};
                    r_rresp  <= r_r_inrange ? RESP_OKAY : RESP_SLVERR;
                    r_rvalid <= 1'b1;
                    r_rstate <= R_RESP;
                end
                R_RESP: begin
                    if (s_RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: begin
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                    r_reg_re  <= 1'b0;
                    r_rstate  <= R_IDLE;
                end
            endcase
        end
    end

    assign s_AWREADY  = r_awready;
    assign s_WREADY   = r_wready;
    assign s_BVALID   = r_bvalid;
    assign s_BRESP    = r_bresp;
    assign s_ARREADY  = r_arready;
    assign s_RVALID   = r_rvalid;
    assign s_RDATA    = r_rdata;
    assign s_RRESP    = r_rresp;
    assign oREG_WE    = r_reg_we;
    assign oREG_RE    = r_reg_re;
    assign oREG_IDX   = r_reg_we ? r_widx : r_ridx;
    assign oREG_WDATA = r_wdata;
    assign oREG_WSTRB = r_wstrb;

endmodule
